// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory target for the single-cycle core: one outstanding
// load/store at a time over valid/ready request and response channels.
module data_memory_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] acc_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [LAT_W-1:0] cnt;
  logic             wr_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      mem [DEPTH];

  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;

  assign req_ready = (state == IDLE) && resetl;
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_addr[2:0] != 3'd0) ||
                     ({3'b000, req_addr[63:3]} >= 64'(DEPTH));
  assign req_idx   = req_addr[IDX_W+2:3];

  // NOTE: the storage array has no reset; contents survive resetl and a
  // committed store is never rolled back by a later abort.
  always_ff @(posedge CLK) begin
    if (accept && req_write && !req_err) mem[req_idx] <= req_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      acc_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q  <= req_write;
            err_q <= req_err;
            idx_q <= req_idx;
            cnt   <= LAT_W'(LATENCY - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : '0;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        RESP: begin
          // Response is held stable until the core takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            acc_count <= acc_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
